// File: rtl/reaction_timer_if.sv
// Handshake/data bundle between the game controller and the reaction_timer core.
interface reaction_timer_if #(
  parameter int COUNT_W = 11
);
  logic               start;
  logic               button;
  logic [COUNT_W-1:0] start_value;
  logic               led_on;
  logic [COUNT_W-1:0] count;
  logic               done;
  logic               false_start;
  logic               timeout;
  logic [COUNT_W-1:0] best;
  logic               best_valid;

  modport master (
    output start, button, start_value,
    input  led_on, count, done, false_start, timeout, best, best_valid
  );

  modport slave (
    input  start, button, start_value,
    output led_on, count, done, false_start, timeout, best, best_valid
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-timer core: prescaled delay countdown, count-up reaction timing, false-start and timeout.
// Optional best-time tracking is enabled by defining REACTION_TIMER_BEST_EN.
//
// state   | meaning
// S_IDLE  | after reset, count = 0
// S_WAIT  | pre-light delay counting down
// S_GO    | light on, reaction ticks counting up
// S_DONE  | valid press or timeout, result held
// S_FALSE | press during delay, remaining delay held
module reaction_timer #(
  parameter int TICK_DIV = 50000,
  parameter int COUNT_W  = 11
) (
  input logic        clk,
  input logic        reset,
  reaction_timer_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FALSE
  } state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               timeout_q, timeout_d;
  logic               button_q;
  logic               btn_edge;
  logic               tick;

  assign btn_edge = bus.button & ~button_q;
  assign tick     = (presc_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
      button_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      button_q  <= bus.button;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = '0;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE, S_FALSE: begin
        if (bus.start) begin
          state_d   = S_WAIT;
          count_d   = bus.start_value;
          timeout_d = 1'b0;
        end
      end
      S_WAIT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (btn_edge) begin
          state_d = S_FALSE;
        end else if (count_q == '0) begin
          state_d = S_GO;
          presc_d = '0;
        end else if (tick) begin
          // the tick that empties the delay also lights the LED
          count_d = count_q - 1'b1;
          if (count_q == COUNT_W'(1)) state_d = S_GO;
        end
      end
      S_GO: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (btn_edge) begin
          state_d = S_DONE;
        end else if (tick) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_MAX - 1'b1) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.led_on      = (state_q == S_GO);
  assign bus.count       = count_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.false_start = (state_q == S_FALSE);
  assign bus.timeout     = (state_q == S_DONE) & timeout_q;

`ifdef REACTION_TIMER_BEST_EN
  logic [COUNT_W-1:0] best_q;
  logic               best_valid_q;
  logic               best_upd;

  // count_q is already the frozen result on the press cycle
  assign best_upd = (state_q == S_GO) & btn_edge &
                    (~best_valid_q | (count_q < best_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else if (best_upd) begin
      best_q       <= count_q;
      best_valid_q <= 1'b1;
    end
  end

  assign bus.best       = best_q;
  assign bus.best_valid = best_valid_q;
`else
  assign bus.best       = '0;
  assign bus.best_valid = 1'b0;
`endif

endmodule
